// File: rtl/clk_gen_multi.sv
// Multi-channel divided-clock generator: CH square waves at clk_i/(2*(div+1)), with
// glitch-free disable and a global sync restart. Define CLK_GEN_MULTI_SHADOW_EN for shadowed divisor loads.
module clk_gen_multi #(
    parameter int CH = 4,
    parameter int CW = 32
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic [CH-1:0]      en_i,
    input  logic [CH*CW-1:0]   div_i,
    input  logic [CH-1:0]      load_i,
    input  logic               sync_i,
    output logic [CH-1:0]      clk_o,
    output logic [CH-1:0]      tick_o,
    output logic [CH-1:0]      run_o,
    output logic [2*CH-1:0]    state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e        state_q      [CH];
    state_e        state_d      [CH];
    logic [CW-1:0] cnt_q        [CH];
    logic [CW-1:0] cnt_d        [CH];
    logic [CW-1:0] active_div_q [CH];
    logic [CW-1:0] active_div_d [CH];
    logic [CH-1:0] clk_q, clk_d;
    logic [CH-1:0] tick_q, tick_d;
    logic [CH-1:0] run_q, run_d;
    logic [CH-1:0] tc;
`ifdef CLK_GEN_MULTI_SHADOW_EN
    logic [CW-1:0] pend_div_q   [CH];
    logic [CW-1:0] pend_div_d   [CH];
    logic [CH-1:0] pend_vld_q, pend_vld_d;
    logic [CH-1:0] apply;
`endif

    always_comb begin
        tc     = '0;
        clk_d  = clk_q;
        tick_d = '0;
        run_d  = '0;
`ifdef CLK_GEN_MULTI_SHADOW_EN
        apply      = '0;
        pend_vld_d = pend_vld_q;
`endif
        for (int n = 0; n < CH; n++) begin
            state_d[n]      = state_q[n];
            cnt_d[n]        = cnt_q[n];
            active_div_d[n] = active_div_q[n];
            tc[n]           = (cnt_q[n] == active_div_q[n]);

            if (sync_i && state_q[n] != ST_IDLE) begin
                cnt_d[n] = '0;
                clk_d[n] = 1'b0;
                if (state_q[n] == ST_DRAIN) state_d[n] = ST_IDLE;
            end else begin
                case (state_q[n])
                    ST_IDLE: begin
                        cnt_d[n] = '0;
                        clk_d[n] = 1'b0;
                        if (en_i[n]) state_d[n] = ST_RUN;
                    end
                    ST_RUN, ST_DRAIN: begin
                        if (tc[n]) begin
                            cnt_d[n] = '0;
                            clk_d[n] = ~clk_q[n];
                        end else begin
                            cnt_d[n] = cnt_q[n] + CW'(1);
                        end
                        // A low output may stop at once; a high one finishes its half-period.
                        if (en_i[n]) begin
                            state_d[n] = ST_RUN;
                        end else if (!clk_q[n] || tc[n]) begin
                            state_d[n] = ST_IDLE;
                            cnt_d[n]   = '0;
                            clk_d[n]   = 1'b0;
                        end else begin
                            state_d[n] = ST_DRAIN;
                        end
                    end
                    default: begin
                        state_d[n] = ST_IDLE;
                        cnt_d[n]   = '0;
                        clk_d[n]   = 1'b0;
                    end
                endcase
            end

`ifdef CLK_GEN_MULTI_SHADOW_EN
            // cnt is zero at every apply point, so a smaller divisor can never be overrun.
            pend_div_d[n] = pend_div_q[n];
            apply[n]      = (state_q[n] == ST_IDLE) || sync_i || tc[n];
            if (apply[n] && pend_vld_q[n]) begin
                active_div_d[n] = pend_div_q[n];
                pend_vld_d[n]   = 1'b0;
            end
            if (load_i[n]) begin
                pend_div_d[n] = div_i[n*CW +: CW];
                pend_vld_d[n] = 1'b1;
            end
`else
            if (load_i[n]) begin
                active_div_d[n] = div_i[n*CW +: CW];
                if (state_d[n] != ST_IDLE && !sync_i) begin
                    cnt_d[n] = '0;
                    clk_d[n] = clk_q[n];
                end
            end
`endif
            tick_d[n] = clk_d[n] & ~clk_q[n];
            run_d[n]  = (state_d[n] != ST_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < CH; n++) begin
                state_q[n]      <= ST_IDLE;
                cnt_q[n]        <= '0;
                active_div_q[n] <= '0;
`ifdef CLK_GEN_MULTI_SHADOW_EN
                pend_div_q[n]   <= '0;
`endif
            end
`ifdef CLK_GEN_MULTI_SHADOW_EN
            pend_vld_q <= '0;
`endif
            clk_q  <= '0;
            tick_q <= '0;
            run_q  <= '0;
        end else begin
            for (int n = 0; n < CH; n++) begin
                state_q[n]      <= state_d[n];
                cnt_q[n]        <= cnt_d[n];
                active_div_q[n] <= active_div_d[n];
`ifdef CLK_GEN_MULTI_SHADOW_EN
                pend_div_q[n]   <= pend_div_d[n];
`endif
            end
`ifdef CLK_GEN_MULTI_SHADOW_EN
            pend_vld_q <= pend_vld_d;
`endif
            clk_q  <= clk_d;
            tick_q <= tick_d;
            run_q  <= run_d;
        end
    end

    always_comb begin
        state_o = '0;
        for (int n = 0; n < CH; n++) state_o[2*n +: 2] = state_q[n];
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign run_o  = run_q;

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi with CH=2, CW=8: a vector table for the basic divide
// behaviour plus hand-written sequences for disable, reset, divisor load, sync and max divisor.
module tb_clk_gen_multi;

    localparam int CH = 2;
    localparam int CW = 8;

    logic               clk_i = 1'b0;
    logic               reset_n;
    logic [CH-1:0]      en_i;
    logic [CH*CW-1:0]   div_i;
    logic [CH-1:0]      load_i;
    logic               sync_i;
    logic [CH-1:0]      clk_o;
    logic [CH-1:0]      tick_o;
    logic [CH-1:0]      run_o;
    logic [2*CH-1:0]    state_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  en;
        logic [1:0]  load;
        logic [15:0] div;
        logic [1:0]  exp_clk;
        logic [1:0]  exp_tick;
        logic [1:0]  exp_run;
    } vec_t;

    vec_t vecs[20];
    logic [31:0] exp_q[$];

    clk_gen_multi #(.CH(CH), .CW(CW)) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .en_i    (en_i),
        .div_i   (div_i),
        .load_i  (load_i),
        .sync_i  (sync_i),
        .clk_o   (clk_o),
        .tick_o  (tick_o),
        .run_o   (run_o),
        .state_o (state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input logic [1:0] en, input logic [1:0] load,
                         input logic [15:0] div, input logic sync);
        en_i   = en;
        load_i = load;
        div_i  = div;
        sync_i = sync;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step_check(input string nm, input logic [1:0] ec,
                              input logic [1:0] et, input logic [1:0] er);
        step();
        check({nm, " clk_o"}, 32'(clk_o), 32'(ec));
        check({nm, " tick_o"}, 32'(tick_o), 32'(et));
        check({nm, " run_o"}, 32'(run_o), 32'(er));
    endtask

    initial begin
        logic       prev;
        logic       d_seq[11];
        logic [31:0] obs_q[$];
        int         ticks;

        // ch0 div=0, ch1 div=3, both enabled at row 2, then both disabled at row 15
        vecs[0]  = '{2'b00, 2'b11, 16'h0300, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b00, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b11, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b11};
        vecs[3]  = '{2'b11, 2'b00, 16'h0300, 2'b01, 2'b01, 2'b11};
        vecs[4]  = '{2'b11, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b11};
        vecs[5]  = '{2'b11, 2'b00, 16'h0300, 2'b01, 2'b01, 2'b11};
        vecs[6]  = '{2'b11, 2'b00, 16'h0300, 2'b10, 2'b10, 2'b11};
        vecs[7]  = '{2'b11, 2'b00, 16'h0300, 2'b11, 2'b01, 2'b11};
        vecs[8]  = '{2'b11, 2'b00, 16'h0300, 2'b10, 2'b00, 2'b11};
        vecs[9]  = '{2'b11, 2'b00, 16'h0300, 2'b11, 2'b01, 2'b11};
        vecs[10] = '{2'b11, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b11};
        vecs[11] = '{2'b11, 2'b00, 16'h0300, 2'b01, 2'b01, 2'b11};
        vecs[12] = '{2'b11, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b11};
        vecs[13] = '{2'b11, 2'b00, 16'h0300, 2'b01, 2'b01, 2'b11};
        vecs[14] = '{2'b11, 2'b00, 16'h0300, 2'b10, 2'b10, 2'b11};
        vecs[15] = '{2'b00, 2'b00, 16'h0300, 2'b10, 2'b00, 2'b10};
        vecs[16] = '{2'b00, 2'b00, 16'h0300, 2'b10, 2'b00, 2'b10};
        vecs[17] = '{2'b00, 2'b00, 16'h0300, 2'b10, 2'b00, 2'b10};
        vecs[18] = '{2'b00, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b00};
        vecs[19] = '{2'b00, 2'b00, 16'h0300, 2'b00, 2'b00, 2'b00};

        // reset state
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 16'h0000, 1'b0);
        #1;
        check("reset clk_o", 32'(clk_o), 32'd0);
        check("reset run_o", 32'(run_o), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("post_reset state_o", 32'(state_o), 32'd0);

        // table: two channels, divisors 0 and 3
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].en, vecs[i].load, vecs[i].div, 1'b0);
            step_check($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_tick, vecs[i].exp_run);
        end

        // disable two cycles into the high phase, div=5: high lasts 6 cycles in total
        drive(2'b00, 2'b01, 16'h0305, 1'b0);
        step();
        drive(2'b00, 2'b00, 16'h0305, 1'b0);
        step();
        drive(2'b01, 2'b00, 16'h0305, 1'b0);
        step_check("b_start", 2'b00, 2'b00, 2'b01);
        for (int i = 1; i <= 5; i++) step_check("b_low", 2'b00, 2'b00, 2'b01);
        step_check("b_rise", 2'b01, 2'b01, 2'b01);
        step_check("b_high1", 2'b01, 2'b00, 2'b01);
        drive(2'b00, 2'b00, 16'h0305, 1'b0);
        for (int i = 0; i < 4; i++) step_check("b_drain", 2'b01, 2'b00, 2'b01);
        check("b_state_drain", 32'(state_o[1:0]), 32'd2);
        step_check("b_fall", 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) step_check("b_quiet", 2'b00, 2'b00, 2'b00);

        // asynchronous reset while clk_o[0] is high
        drive(2'b01, 2'b00, 16'h0305, 1'b0);
        step();
        for (int i = 0; i < 6; i++) step();
        check("c_high_before_reset", 32'(clk_o), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("c_async clk_o", 32'(clk_o), 32'd0);
        check("c_async tick_o", 32'(tick_o), 32'd0);
        check("c_async run_o", 32'(run_o), 32'd0);
        drive(2'b00, 2'b00, 16'h0305, 1'b0);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step_check("c_no_toggle", 2'b00, 2'b00, 2'b00);
        // reset cleared the divisor, so the channel now runs at clk_i/2
        drive(2'b01, 2'b00, 16'h0305, 1'b0);
        step_check("c_reen", 2'b00, 2'b00, 2'b01);
        step_check("c_rise", 2'b01, 2'b01, 2'b01);
        drive(2'b00, 2'b00, 16'h0305, 1'b0);
        step_check("c_stop", 2'b00, 2'b00, 2'b00);

        // divisor load mid-half-period: div=4 running, load div=1
        drive(2'b00, 2'b01, 16'h0204, 1'b0);
        step();
        drive(2'b00, 2'b00, 16'h0204, 1'b0);
        step();
        drive(2'b01, 2'b00, 16'h0204, 1'b0);
        step_check("d_start", 2'b00, 2'b00, 2'b01);
        for (int i = 1; i <= 4; i++) step_check("d_low", 2'b00, 2'b00, 2'b01);
        step_check("d_rise", 2'b01, 2'b01, 2'b01);
`ifdef CLK_GEN_MULTI_SHADOW_EN
        d_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        d_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        prev = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 1) drive(2'b01, 2'b01, 16'h0201, 1'b0);
            else        drive(2'b01, 2'b00, 16'h0201, 1'b0);
            step_check($sformatf("d_load%0d", k), {1'b0, d_seq[k]}, {1'b0, d_seq[k] & ~prev}, 2'b01);
            prev = d_seq[k];
        end
        drive(2'b00, 2'b00, 16'h0201, 1'b0);
        for (int i = 0; i < 4; i++) step();
        step_check("d_idle", 2'b00, 2'b00, 2'b00);

        // sync: both channels div=2, started 3 cycles apart, then realigned
        drive(2'b00, 2'b11, 16'h0202, 1'b0);
        step();
        drive(2'b00, 2'b00, 16'h0202, 1'b0);
        step();
        drive(2'b01, 2'b00, 16'h0202, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive(2'b11, 2'b00, 16'h0202, 1'b0);
        for (int i = 0; i < 5; i++) step();
        drive(2'b11, 2'b00, 16'h0202, 1'b1);
        step_check("e_sync", 2'b00, 2'b00, 2'b11);
        drive(2'b11, 2'b00, 16'h0202, 1'b0);
        step_check("e_s1", 2'b00, 2'b00, 2'b11);
        step_check("e_s2", 2'b00, 2'b00, 2'b11);
        step_check("e_s3", 2'b11, 2'b11, 2'b11);
        step_check("e_s4", 2'b11, 2'b00, 2'b11);
        step_check("e_s5", 2'b11, 2'b00, 2'b11);
        step_check("e_s6", 2'b00, 2'b00, 2'b11);
        drive(2'b00, 2'b00, 16'h0202, 1'b0);
        for (int i = 0; i < 5; i++) step();
        step_check("e_idle", 2'b00, 2'b00, 2'b00);

        // maximum divisor: half-period 256 cycles, no counter wrap
        drive(2'b00, 2'b01, 16'h02FF, 1'b0);
        step();
        drive(2'b00, 2'b00, 16'h02FF, 1'b0);
        step();
        drive(2'b01, 2'b00, 16'h02FF, 1'b0);
        step();
        exp_q = {32'd256, 32'd512, 32'd768};
        prev  = 1'b0;
        ticks = 0;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (clk_o[0] != prev) obs_q.push_back(32'(i));
            if (tick_o[0]) ticks++;
            prev = clk_o[0];
        end
        check("f_edge_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check("f_edge_time", obs_q.pop_front(), exp_q.pop_front());
        end
        check("f_ticks", 32'(ticks), 32'd2);
        drive(2'b00, 2'b00, 16'h02FF, 1'b0);
        for (int i = 0; i < 230; i++) step();
        step_check("f_idle", 2'b00, 2'b00, 2'b00);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
